alu16_seq: RTL and testbench
============================

Name: alu16_seq

Overview:
- Request sequencer directly upstream of the 16-bit ALU (alu16).
- Accepts operand/opcode requests over a valid/ready handshake and drives the ALU's a, b, aluOp, shamt and reset inputs.
- Runs the reset-pulse/ready protocol for the multi-cycle multiply op; other ops are treated as single-cycle.
- Returns result/zero over a valid/ready response handshake. Removes hand-timed stimulus from every ALU consumer.

Parameters:
- MULT_OP, 3'd1: aluOp encoding that is multi-cycle (waits on alu_ready).
- MAX_WAIT, 64: timeout cycles in WAIT; used only with ALU_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_a  in  16  operand a.
- req_b  in  16  operand b.
- req_op  in  3  ALU opcode.
- req_shamt  in  4  shift amount.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_result  out  16  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.
- rsp_err  out  1  timeout flag; 0 without macro.
- op_count  out  16  completed-response counter.
- alu_a  out  16  to ALU a.
- alu_b  out  16  to ALU b.
- alu_op  out  3  to ALU aluOp.
- alu_shamt  out  4  to ALU shamt.
- alu_reset  out  1  to ALU reset.
- alu_result  in  16  from ALU result.
- alu_zero  in  1  from ALU zero.
- alu_ready  in  1  from ALU ready.

Behaviour:
- Reset (async, reset=1), all values hold while asserted:
  - state=IDLE; alu_a/alu_b/alu_op/alu_shamt=0; alu_reset=1.
  - rsp_valid=0; rsp_result=0; rsp_zero=0; rsp_err=0; op_count=0.
- Reset mid-operation: abort immediately to the reset values above; the in-flight request is lost and no response is issued.
- States: IDLE, START, SETTLE, WAIT, RESP.
- req_ready=1 only in IDLE. alu_reset=1 in IDLE and START, 0 in SETTLE, WAIT and RESP.
- IDLE: on an edge with req_valid=1, latch req_a/b/op/shamt into alu_a/b/op/shamt.
  - req_op==MULT_OP: go to START.
  - Otherwise: go to SETTLE.
- START: exactly one cycle, ALU held in reset with the new operands -> WAIT; clear wait counter.
- SETTLE: one cycle. At its closing edge, rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_err<=0 -> RESP. rsp_valid rises 2 cycles after the accept edge.
- WAIT:
  - alu_ready is ignored in the first WAIT cycle (may be stale).
  - From the second cycle on, the first edge with alu_ready=1 captures result/zero, rsp_err<=0 -> RESP.
  - Multiply latency is therefore 3 + ALU compute cycles after accept.
- RESP: rsp_valid=1; rsp_result/rsp_zero/rsp_err held stable.
  - On an edge with rsp_ready=1: op_count<=op_count+1 (wraps 0xFFFF->0x0000) -> IDLE.
  - rsp_ready while not in RESP has no effect.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after a response handshake. req_valid held through RESP is accepted in the following IDLE cycle.
- alu_a/b/op/shamt stay stable from accept until the next accept.
- Captured response regs are unaffected by ALU input changes after capture.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A 7-bit wait counter increments each WAIT cycle.
  - If it reaches MAX_WAIT with no valid alu_ready, go to RESP with rsp_result=0, rsp_zero=0, rsp_err=1.
  - A timed-out response still increments op_count on handshake.
- Undefined: no counter; WAIT waits indefinitely; rsp_err is constant 0.

Test Plan:
- Reset: assert reset mid-WAIT -> next sample shows state IDLE, rsp_valid=0, alu_reset=1, op_count=0, req_ready=1.
- Multiply with real alu16: req a=7, b=289, op=3'd1, shamt=2 -> one cycle with alu_reset=1 after accept; rsp_result=16'd2023 (0x07E7), rsp_zero=0, rsp_err=0; rsp_ready=1 -> op_count=1.
- Single-cycle op with real alu16: op=3'd2, a=40, b=40 -> rsp_valid exactly 2 cycles after accept; rsp_result/rsp_zero equal alu_result/alu_zero sampled at SETTLE's closing edge.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP with ALU inputs toggling -> rsp_result stable, req_ready=0; release -> returns to IDLE, op_count increments once.
- Stale ready with stub ALU: alu_ready=1 in the first WAIT cycle then 0 for 5 cycles then 1 -> capture occurs only on the later assertion.
- Timeout, macro on, stub ALU with alu_ready stuck 0, MAX_WAIT=64 -> rsp_valid=1, rsp_err=1, rsp_result=0. With macro off -> still in WAIT after 200 cycles.

Source files
------------

// File: rtl/alu16_seq.sv
// Request sequencer in front of alu16: latches operands, runs the multiply reset/ready handshake, returns result/zero.
// Optional WAIT timeout guarded by ALU_SEQ_TIMEOUT_EN (rsp_err tied low when undefined).
module alu16_seq #(
    parameter logic [2:0] MULT_OP  = 3'd1,
    parameter int         MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [15:0] op_count,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic [3:0]  alu_shamt,
    output logic        alu_reset,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [3:0]  alu_shamt_q, alu_shamt_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic [15:0] op_count_q, op_count_d;
    logic        capture;
    logic        expire;
    logic        wait_armed;
    logic        wait_timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic [6:0] wait_cnt_q, wait_cnt_d;
    logic       rsp_err_q, rsp_err_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_START) begin
            wait_cnt_d = 7'd0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 7'd1;
        end
    end

    // A count of zero marks the first WAIT cycle, where alu_ready may still be stale.
    assign wait_armed   = (wait_cnt_q != 7'd0);
    assign wait_timeout = (wait_cnt_q == 7'(MAX_WAIT - 1));

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (expire) begin
            rsp_err_d = 1'b1;
        end else if (capture) begin
            rsp_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 7'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic wait_first_q, wait_first_d;
    logic unused_max_wait;

    always_comb begin
        wait_first_d = wait_first_q;
        if (state_q == S_START) begin
            wait_first_d = 1'b1;
        end else if (state_q == S_WAIT) begin
            wait_first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_first_q <= 1'b0;
        end else begin
            wait_first_q <= wait_first_d;
        end
    end

    assign wait_armed      = !wait_first_q;
    assign wait_timeout    = 1'b0;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign rsp_err         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_shamt_d = alu_shamt_q;
        op_count_d  = op_count_q;
        capture     = 1'b0;
        expire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    alu_a_d     = req_a;
                    alu_b_d     = req_b;
                    alu_op_d    = req_op;
                    alu_shamt_d = req_shamt;
                    state_d     = (req_op == MULT_OP) ? S_START : S_SETTLE;
                end
            end
            S_START:  state_d = S_WAIT;
            S_SETTLE: begin
                capture = 1'b1;
                state_d = S_RESP;
            end
            S_WAIT: begin
                if (wait_armed && alu_ready) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (wait_timeout) begin
                    expire  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        if (capture) begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
        end else if (expire) begin
            rsp_result_d = 16'd0;
            rsp_zero_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            alu_a_q      <= 16'd0;
            alu_b_q      <= 16'd0;
            alu_op_q     <= 3'd0;
            alu_shamt_q  <= 4'd0;
            rsp_result_q <= 16'd0;
            rsp_zero_q   <= 1'b0;
            op_count_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_shamt_q  <= alu_shamt_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign alu_reset  = (state_q == S_IDLE) || (state_q == S_START);
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign op_count   = op_count_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_shamt  = alu_shamt_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: stub ALU plus a response-queue model checked every cycle, and directed latency/value checks.
module tb_alu16_seq;

    localparam logic [2:0] MULT = 3'd1;
    localparam int         MAXW = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [2:0]  req_op;
    logic [3:0]  req_shamt;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero, rsp_err;
    logic [15:0] op_count;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_shamt;
    logic        alu_reset;
    logic [15:0] alu_result;
    logic        alu_zero, alu_ready;

    logic        stub_done, stub_ready;
    logic [15:0] noise;
    logic        expect_to;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int hs_cyc = -1;

    logic [17:0] exp_q[$];
    logic [15:0] model_cnt;
    logic [15:0] m_a, m_b;
    logic [2:0]  m_op;
    logic [3:0]  m_sh;

    alu16_seq #(.MULT_OP(MULT), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .op_count(op_count),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_reset(alu_reset),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_ready(alu_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op, input logic [3:0] sh);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a * b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    // Stub ALU: an unfinished multiply shows a junk value so a premature capture is visible.
    assign alu_result = (alu_op == MULT && !stub_done) ? 16'hDEAD
                                                       : (alu_f(alu_a, alu_b, alu_op, alu_shamt) ^ noise);
    assign alu_zero   = (alu_result == 16'd0);
    assign alu_ready  = stub_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: what was accepted, what responses are owed, how many have been taken.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_cnt = 16'd0;
            m_a = 16'd0; m_b = 16'd0; m_op = 3'd0; m_sh = 4'd0;
        end else begin
            if (req_valid && req_ready) begin
                logic [15:0] r;
                r = alu_f(req_a, req_b, req_op, req_shamt);
                if (expect_to && req_op == MULT) exp_q.push_back({1'b1, 1'b0, 16'd0});
                else exp_q.push_back({1'b0, (r == 16'd0), r});
                m_a = req_a; m_b = req_b; m_op = req_op; m_sh = req_shamt;
                acc_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                model_cnt = model_cnt + 16'd1;
                hs_cyc = cyc;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_alu_reset", alu_reset, 1);
            chk("rst_op_count", op_count, 0);
            chk("rst_rsp_result", {rsp_err, rsp_zero, rsp_result}, 0);
            chk("rst_alu_in", {alu_a, alu_b, alu_op, alu_shamt}, 0);
        end else begin
            chk("op_count", op_count, model_cnt);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op_shamt", {alu_op, alu_shamt}, {m_op, m_sh});
            chk("req_rsp_excl", (req_ready && rsp_valid), 0);
            if (req_ready) chk("idle_alu_reset", alu_reset, 1);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    chk("rsp_result", rsp_result, exp_q[0][15:0]);
                    chk("rsp_zero", rsp_zero, exp_q[0][16]);
                    chk("rsp_err", rsp_err, exp_q[0][17]);
                    chk("rsp_alu_reset", alu_reset, 0);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic [3:0] sh);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_shamt = sh;
    endtask

    task automatic wait_accept;
        int n = 0;
        while (!req_ready && n < 300) begin step; n++; end
        chk("accept_wait", req_ready, 1);
        step;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int lim);
        int n = 0;
        while (!rsp_valid && n < lim) begin step; n++; end
        chk("rsp_wait", rsp_valid, 1);
    endtask

    task automatic take_rsp;
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_a = 16'd0; req_b = 16'd0; req_op = 3'd0; req_shamt = 4'd0;
        rsp_ready = 1'b0; stub_done = 1'b0; stub_ready = 1'b0; noise = 16'd0; expect_to = 1'b0;
        repeat (3) step;
        reset = 1'b0;
        step;

        // Single-cycle subtract: 40-40 = 0, zero flag set, response two cycles after accept.
        set_req(16'd40, 16'd40, 3'd2, 4'd0);
        wait_accept;
        wait_rsp(300);
        chk("single_latency", cyc - acc_cyc, 2);
        chk("single_result", rsp_result, 16'h0000);
        chk("single_zero", rsp_zero, 1);
        chk("single_err", rsp_err, 0);
        take_rsp;
        chk("single_count", op_count, 1);
        chk("single_idle", req_ready, 1);

        // Multiply 7*289 = 2023; three compute cycles of WAIT before ready.
        set_req(16'd7, 16'd289, MULT, 4'd2);
        wait_accept;
        chk("mul_start_reset", alu_reset, 1);
        step;
        chk("mul_wait_reset", alu_reset, 0);
        repeat (3) step;
        stub_done = 1'b1; stub_ready = 1'b1;
        wait_rsp(300);
        stub_ready = 1'b0;
        chk("mul_latency", cyc - acc_cyc, 6);
        chk("mul_result", rsp_result, 16'h07E7);
        chk("mul_zero", rsp_zero, 0);
        take_rsp;
        chk("mul_count", op_count, 2);

        // Backpressure with ALU output toggling and a new request held pending.
        set_req(16'h1234, 16'h00FF, 3'd3, 4'd0);
        wait_accept;
        wait_rsp(300);
        set_req(16'hF0F0, 16'h0FF0, 3'd5, 4'd0);
        for (int i = 0; i < 10; i++) begin
            noise = 16'($urandom);
            step;
            chk("bp_result", rsp_result, 16'h0034);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_valid", rsp_valid, 1);
        end
        noise = 16'd0;
        take_rsp;
        chk("bp_count", op_count, 3);
        chk("bp_idle", req_ready, 1);
        step;
        req_valid = 1'b0;
        chk("bp_accept_next", acc_cyc - hs_cyc, 1);
        wait_rsp(300);
        chk("held_req_result", rsp_result, 16'hFF00);
        take_rsp;
        chk("held_req_count", op_count, 4);

        // Stale ready in first WAIT cycle must not capture the junk value.
        stub_done = 1'b0; stub_ready = 1'b0;
        set_req(16'd3, 16'd5, MULT, 4'd0);
        wait_accept;
        step;
        stub_ready = 1'b1;
        step;
        stub_ready = 1'b0;
        chk("stale_no_capture", rsp_valid, 0);
        repeat (5) begin
            step;
            chk("stale_still_wait", rsp_valid, 0);
        end
        stub_done = 1'b1; stub_ready = 1'b1;
        wait_rsp(300);
        stub_ready = 1'b0;
        chk("stale_latency", cyc - acc_cyc, 9);
        chk("stale_result", rsp_result, 16'd15);
        take_rsp;
        chk("stale_count", op_count, 5);

        // Reset asserted mid-WAIT drops the request.
        stub_done = 1'b0; stub_ready = 1'b0;
        set_req(16'd9, 16'd9, MULT, 4'd0);
        wait_accept;
        step;
        step;
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_alu_reset", alu_reset, 1);
        chk("midrst_op_count", op_count, 0);
        step;
        reset = 1'b0;
        repeat (3) step;
        chk("postrst_idle", req_ready, 1);

`ifdef ALU_SEQ_TIMEOUT_EN
        expect_to = 1'b1;
        set_req(16'd2, 16'd3, MULT, 4'd0);
        wait_accept;
        wait_rsp(300);
        chk("to_latency", cyc - acc_cyc, 2 + MAXW);
        chk("to_err", rsp_err, 1);
        chk("to_result", rsp_result, 16'd0);
        take_rsp;
        chk("to_count", op_count, 1);
        expect_to = 1'b0;
`else
        set_req(16'd2, 16'd3, MULT, 4'd0);
        wait_accept;
        repeat (200) step;
        chk("no_timeout_valid", rsp_valid, 0);
        chk("no_timeout_busy", req_ready, 0);
        chk("no_timeout_err", rsp_err, 0);
`endif
        reset = 1'b1;
        step;
        reset = 1'b0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
